// File: rtl/quad_pkg.sv
// Shared types and helpers for the steering quadrature decoder.
package quad_pkg;

  typedef logic [1:0] phase_t;  // {A,B}

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  // Forward (right) Gray sequence: 00 -> 10 -> 11 -> 01 -> 00
  function automatic phase_t fwd_next(input phase_t p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-line glitch filter: output follows the input only after FILT_LEN
// consecutive cycles of disagreement; any agreement restarts the count.
module quad_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [3:0] r_cnt;
  logic       r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == 4'(FILT_LEN - 1)) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/quad_steer_decoder.sv
// x4 quadrature decoder for the steering pins: sync, optional glitch filter
// (QUAD_GLITCH_FILTER_EN), wrapping position and saturating read-clear delta.
module quad_steer_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             CLK,
  input  logic             Reset_I,
  input  logic             SteerA_I,
  input  logic             SteerB_I,
  input  logic             Clear_I,
  input  logic             Rd_I,
  input  logic             ErrClr_I,
  output logic             Step_O,
  output logic             Dir_O,
  output logic [CNT_W-1:0] Pos_O,
  output logic [CNT_W-1:0] Delta_O,
  output logic             Err_O
);

`ifdef QUAD_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  // Priming is held off until a real pin sample has crossed the sync/filter
  // pipeline, so reset-value zeros never look like a transition.
  localparam int WARM = SYNC_STAGES + 1 + (FILT_ON ? FILT_LEN : 0);

  localparam logic [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
  logic [1:0]             w_sync, w_filt;
  logic [WARM-1:0]        r_vld_pipe;
  phase_t                 r_prev, w_cur;
  logic                   w_primed, w_fwd, w_rev, w_ill;
  logic                   r_step, r_dir, r_err;
  logic [CNT_W-1:0]       r_pos, r_acc, r_delta, w_acc_nxt;

  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], SteerA_I};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], SteerB_I};
    end
  end

  assign w_sync = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
  for (genvar g = 0; g < 2; g++) begin : g_filt
    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .i_clk   (CLK),
      .i_rst_n (Reset_I),
      .i_d     (w_sync[g]),
      .o_q     (w_filt[g])
    );
  end
`else
  assign w_filt = w_sync;
`endif

  assign w_cur    = w_filt;
  assign w_primed = r_vld_pipe[WARM-1];
  assign w_fwd    = w_primed && (w_cur == fwd_next(r_prev));
  assign w_rev    = w_primed && (r_prev == fwd_next(w_cur));
  assign w_ill    = w_primed && ((w_cur ^ r_prev) == 2'b11);

  always_comb begin
    w_acc_nxt = r_acc;
    if (w_fwd && (r_acc != ACC_MAX))
      w_acc_nxt = r_acc + CNT_W'(1);
    else if (w_rev && (r_acc != ACC_MIN))
      w_acc_nxt = r_acc - CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge Reset_I) begin
    if (!Reset_I) begin
      r_vld_pipe <= '0;
      r_prev     <= '0;
      r_step     <= 1'b0;
      r_dir      <= DIR_LEFT;
      r_err      <= 1'b0;
      r_pos      <= '0;
      r_acc      <= '0;
      r_delta    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[WARM-2:0], 1'b1};
      r_prev     <= w_cur;  // illegal jumps and Clear still track the pins
      r_step     <= w_fwd | w_rev;
      if (w_fwd)
        r_dir <= DIR_RIGHT;
      else if (w_rev)
        r_dir <= DIR_LEFT;
      if (w_ill)
        r_err <= 1'b1;
      else if (ErrClr_I)
        r_err <= 1'b0;
      if (Clear_I) begin
        r_pos <= '0;
        r_acc <= '0;
      end else begin
        if (w_fwd)
          r_pos <= r_pos + CNT_W'(1);
        else if (w_rev)
          r_pos <= r_pos - CNT_W'(1);
        if (Rd_I) begin
          r_delta <= w_acc_nxt;
          r_acc   <= '0;
        end else begin
          r_acc <= w_acc_nxt;
        end
      end
    end
  end

  assign Step_O  = r_step;
  assign Dir_O   = r_dir;
  assign Pos_O   = r_pos;
  assign Delta_O = r_delta;
  assign Err_O   = r_err;

endmodule
